// File: rtl/fifo_rptr_rempty.sv
// Read-side pointer and empty-flag logic for an asynchronous FIFO.
// Synchronises the Gray write pointer into the read clock domain. Keeps the
// binary and Gray read pointers, and produces the registered empty flag and
// a sticky underflow flag.
// Optional feature (macro FIFO_RLEVEL_EN): adds the fill level and the
// almost-empty outputs, both computed from the synchronised write pointer.
module fifo_rptr_rempty #(
    parameter int Address   = 3,
    parameter int AE_Thresh = 1
) (
    input  logic               Rclk,
    input  logic               Rrst,
    input  logic               Rinc,
    input  logic [Address:0]   Wptr,
    output logic [Address-1:0] Radder,
    output logic [Address:0]   Rptr,
    output logic               Rempty,
    output logic               Runderflow
`ifdef FIFO_RLEVEL_EN
    ,
    output logic [Address:0]   Rlevel,
    output logic               Ralmost_empty
`endif
);

    logic [Address:0] rq1_wptr;
    logic [Address:0] rq2_wptr;
    logic [Address:0] rbin;
    logic [Address:0] rbin_next;
    logic [Address:0] rgray_next;
    logic             read_ok;

    // Two-flop synchroniser: the only place the foreign-domain pointer is sampled
    always_ff @(posedge Rclk) begin
        if (!Rrst) begin
            rq1_wptr <= '0;
            rq2_wptr <= '0;
        end else begin
            rq1_wptr <= Wptr;
            rq2_wptr <= rq1_wptr;
        end
    end

    // Next-pointer arithmetic: a read while empty is ignored
    always_comb begin
        read_ok    = Rinc & ~Rempty;
        rbin_next  = rbin + {{Address{1'b0}}, read_ok};
        rgray_next = (rbin_next >> 1) ^ rbin_next;
    end

    // Pointer, empty and sticky underflow registers
    always_ff @(posedge Rclk) begin
        if (!Rrst) begin
            rbin       <= '0;
            Rptr       <= '0;
            Rempty     <= 1'b1;
            Runderflow <= 1'b0;
        end else begin
            rbin       <= rbin_next;
            Rptr       <= rgray_next;
            Rempty     <= (rgray_next == rq2_wptr);
            Runderflow <= Runderflow | (Rinc & Rempty);
        end
    end

    assign Radder = rbin[Address-1:0];

`ifdef FIFO_RLEVEL_EN
    localparam logic [Address:0] AeThresh = AE_Thresh[Address:0];

    logic [Address:0] wbin_s;
    logic [Address:0] level_next;

    // Gray-to-binary conversion of the synchronised write pointer, then the fill level
    always_comb begin
        wbin_s = '0;
        for (int i = 0; i <= Address; i++) begin
            wbin_s[i] = ^(rq2_wptr >> i);
        end
        level_next = wbin_s - rbin_next;
    end

    // Registered fill level and almost-empty flag
    always_ff @(posedge Rclk) begin
        if (!Rrst) begin
            Rlevel        <= '0;
            Ralmost_empty <= 1'b1;
        end else begin
            Rlevel        <= level_next;
            Ralmost_empty <= (level_next <= AeThresh);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rptr_rempty.sv
// Self-checking bench for fifo_rptr_rempty. Stimulus pushes expected results
// into a scoreboard queue, and an independent monitor pops them and compares.
// The reference model tracks read and write counts as plain integers.
// If FIFO_RLEVEL_EN is defined, the level outputs are connected and checked.
module tb_fifo_rptr_rempty;

    localparam int A = 3;

    logic         clk;
    logic         Rrst;
    logic         Rinc;
    logic [A:0]   Wptr;
    logic [A-1:0] Radder;
    logic [A:0]   Rptr;
    logic         Rempty;
    logic         Runderflow;
`ifdef FIFO_RLEVEL_EN
    logic [A:0]   Rlevel;
    logic         Ralmost_empty;
`endif

    fifo_rptr_rempty #(.Address(A), .AE_Thresh(1)) dut (
        .Rclk          (clk),
        .Rrst          (Rrst),
        .Rinc          (Rinc),
        .Wptr          (Wptr),
        .Radder        (Radder),
        .Rptr          (Rptr),
        .Rempty        (Rempty),
        .Runderflow    (Runderflow)
`ifdef FIFO_RLEVEL_EN
        ,
        .Rlevel        (Rlevel),
        .Ralmost_empty (Ralmost_empty)
`endif
    );

    typedef struct packed {
        logic [A:0]   rptr;
        logic [A-1:0] radder;
        logic         rempty;
        logic         runder;
        logic [A:0]   rlevel;
        logic         rae;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;
    bit   done   = 0;

    // Model state: counts of entries read and written, plus the write counts
    // still travelling through the two synchroniser stages.
    logic [A:0] m_rd;
    logic [A:0] m_s1;
    logic [A:0] m_s2;
    logic       m_empty;
    logic       m_under;
    logic [A:0] m_level;
    logic       m_ae;
    logic [A:0] wc;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Drive one cycle on the falling edge and push what the next rising edge must show
    task automatic applyStimulus(input logic rst_n, input logic rinc, input logic [A:0] wcount);
        logic [A:0] vis;
        exp_t       e;
        @(negedge clk);
        Rrst = rst_n;
        Rinc = rinc;
        Wptr = wcount ^ (wcount >> 1);
        if (!rst_n) begin
            m_rd = 0; m_s1 = 0; m_s2 = 0;
            m_empty = 1; m_under = 0; m_level = 0; m_ae = 1;
        end else begin
            if (rinc && m_empty) m_under = 1;
            if (rinc && !m_empty) m_rd = m_rd + 1;
            vis     = m_s2;
            m_s2    = m_s1;
            m_s1    = wcount;
            m_empty = (m_rd == vis);
            m_level = vis - m_rd;
            m_ae    = (m_level <= 1);
        end
        e.rptr   = m_rd ^ (m_rd >> 1);
        e.radder = m_rd[A-1:0];
        e.rempty = m_empty;
        e.runder = m_under;
        e.rlevel = m_level;
        e.rae    = m_ae;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        check("Rptr",       int'(Rptr),       int'(e.rptr));
        check("Radder",     int'(Radder),     int'(e.radder));
        check("Rempty",     int'(Rempty),     int'(e.rempty));
        check("Runderflow", int'(Runderflow), int'(e.runder));
`ifdef FIFO_RLEVEL_EN
        check("Rlevel",        int'(Rlevel),        int'(e.rlevel));
        check("Ralmost_empty", int'(Ralmost_empty), int'(e.rae));
`endif
    endtask

    // Monitor: sample just after each rising edge and compare against the scoreboard
    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, wc);
    endtask

    task automatic reads(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, wc);
    endtask

    initial begin
        Rrst = 0; Rinc = 0; Wptr = '0; wc = '0;
        m_rd = 0; m_s1 = 0; m_s2 = 0; m_empty = 1; m_under = 0; m_level = 0; m_ae = 1;

        // Reset for two edges, then idle while empty
        applyStimulus(1'b0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 0);
        idle(2);

        // Underflow: one read request while empty, flag must stick
        applyStimulus(1'b1, 1'b1, wc);
        idle(3);

        // Single write crosses the synchroniser with two-edge latency
        wc = 1;
        idle(4);

        // Eight entries written, drain all of them
        wc = 8;
        idle(3);
        reads(8);
        idle(2);

        // Wrap: sixteen written in total, drain eight more
        wc = 0;
        idle(3);
        reads(8);
        idle(2);

        // Mid-drain reset with the writer also returning to zero
        wc = 8;
        idle(3);
        reads(3);
        wc = 0;
        applyStimulus(1'b0, 1'b1, wc);
        idle(4);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [A:0] occ;
            logic       rinc;
            rinc = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0) begin
                wc = 0;
                applyStimulus(1'b0, rinc, wc);
            end else begin
                occ = wc - m_rd;
                if (occ < 8 && $urandom_range(0, 2) != 0) wc = wc + 1;
                applyStimulus(1'b1, rinc, wc);
            end
        end
        idle(2);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
